divider_unit: RTL and testbench

DIVIDER_UNIT -- requirements
Module: divider_unit

---
 rtl/divider_unit.sv | 139 +++++++++++++
 tb/tb_divider_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/divider_unit.sv
// rtl/divider_unit.sv - 8-bit unsigned restoring divider driven by push buttons
module divider_unit (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       ClearA_LoadB,
    input  logic [7:0] S,
    output logic [7:0] Aval,
    output logic [7:0] Bval,
    output logic [7:0] Qval,
    output logic       X,
    output logic       Busy,
    output logic       Done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic [7:0] q_q, q_d;
    logic [2:0] cnt_q, cnt_d;
    logic       x_q, x_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    // One restoring step on {A,Q}: shift left, then try to subtract B.
    // The trial difference is one bit wider so its MSB is the borrow.
    logic [7:0] a_shift;
    logic [7:0] q_shift;
    logic [8:0] trial_diff;

    // Shifted operands and trial subtraction for the current iteration
    always_comb begin
        a_shift    = {a_q[6:0], q_q[7]};
        q_shift    = {q_q[6:0], 1'b0};
        trial_diff = {1'b0, a_shift} - {1'b0, b_q};
    end

    // Next-state and register update logic; everything holds by default
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        busy_d  = busy_q;
        done_d  = done_q;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                done_d = 1'b0;
                // Loading the divisor wins over starting a division so that
                // pressing both buttons together never runs on a stale B.
                if (!ClearA_LoadB) begin
                    b_d = S;
                    a_d = 8'h00;
                end else if (!Run) begin
                    q_d     = S;
                    a_d     = 8'h00;
                    cnt_d   = 3'd0;
                    x_d     = (b_q == 8'h00);
                    state_d = CALC;
                    busy_d  = 1'b1;
                end
            end

            CALC: begin
                // Buttons are deliberately not looked at here; the division
                // always runs its full eight iterations, even for B == 0.
                if (!trial_diff[8]) begin
                    a_d = trial_diff[7:0];
                    q_d = q_shift | 8'h01;
                end else begin
                    a_d = a_shift;
                    q_d = q_shift;
                end
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = HOLD;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end

            HOLD: begin
                // Result stays frozen until Run is released, so a held
                // button yields exactly one division per press.
                if (Run) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-high reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            q_q     <= 8'h00;
            cnt_q   <= 3'd0;
            x_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Aval = a_q;
    assign Bval = b_q;
    assign Qval = q_q;
    assign X    = x_q;
    assign Busy = busy_q;
    assign Done = done_q;

endmodule

// File: tb/tb_divider_unit.sv
// tb/tb_divider_unit.sv - directed scoreboard bench for divider_unit
module tb_divider_unit;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Run = 1'b1;
    logic       ClearA_LoadB = 1'b1;
    logic [7:0] S = 8'h00;
    logic [7:0] Aval, Bval, Qval;
    logic       X, Busy, Done;

    divider_unit dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Run          (Run),
        .ClearA_LoadB (ClearA_LoadB),
        .S            (S),
        .Aval         (Aval),
        .Bval         (Bval),
        .Qval         (Qval),
        .X            (X),
        .Busy         (Busy),
        .Done         (Done)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic       x;
    } exp_t;

    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] b_model = 8'h00;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic load_b(input logic [7:0] v);
        logic [7:0] q_before;
        q_before     = Qval;
        ClearA_LoadB = 1'b0;
        S            = v;
        step();
        ClearA_LoadB = 1'b1;
        b_model      = v;
        chk("load_b", Bval, v);
        chk("load_a", Aval, 8'h00);
        chk("load_q", Qval, q_before);
    endtask

    // Start one division, check latency/busy width, pop the scoreboard on
    // Done, optionally keep Run held, and optionally poke ClearA_LoadB
    // while the divider is supposed to ignore it.
    task automatic run_div(input logic [7:0] dvd, input int hold, input bit poke_load);
        exp_t e;
        int   lat;
        int   busy_cnt;
        e.b = b_model;
        e.x = (b_model == 8'h00);
        e.q = (b_model == 8'h00) ? 8'hFF : dvd / b_model;
        e.a = (b_model == 8'h00) ? dvd   : dvd % b_model;
        sb.push_back(e);
        S   = dvd;
        Run = 1'b0;
        lat = 0;
        busy_cnt = 0;
        while (!Done && lat < 20) begin
            step();
            lat++;
            if (Busy) busy_cnt++;
            if (poke_load) begin
                ClearA_LoadB = 1'b0;
                S            = 8'h09;
            end
        end
        chk("latency", lat, 9);
        chk("busy_cycles", busy_cnt, 8);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("result_q", Qval, e.q);
            chk("result_a", Aval, e.a);
            chk("result_b", Bval, e.b);
            chk("result_x", X, e.x);
        end
        repeat (hold) step();
        if (hold > 0 || poke_load) begin
            step();
            chk("hold_done", Done, 1'b1);
            chk("hold_busy", Busy, 1'b0);
            chk("hold_q", Qval, e.q);
            chk("hold_a", Aval, e.a);
            chk("hold_b", Bval, e.b);
        end
        ClearA_LoadB = 1'b1;
        Run          = 1'b1;
        step();
        chk("release_done", Done, 1'b0);
        chk("release_busy", Busy, 1'b0);
    endtask

    initial begin
        // Reset state
        Reset = 1'b1;
        step();
        step();
        Reset = 1'b0;
        chk("rst_a", Aval, 8'h00);
        chk("rst_b", Bval, 8'h00);
        chk("rst_q", Qval, 8'h00);
        chk("rst_x", X, 1'b0);
        chk("rst_busy", Busy, 1'b0);
        chk("rst_done", Done, 1'b0);

        // Basic division 100 / 7
        load_b(8'h07);
        run_div(8'h64, 0, 1'b0);

        // Divide by zero
        load_b(8'h00);
        run_div(8'hA5, 0, 1'b0);

        // Boundaries
        load_b(8'h01);
        run_div(8'hFF, 0, 1'b0);
        load_b(8'hFF);
        run_div(8'h03, 0, 1'b0);
        run_div(8'hFF, 0, 1'b0);

        // Run held for 30 cycles after start, then a fresh press reusing B
        load_b(8'h03);
        run_div(8'h20, 21, 1'b0);
        run_div(8'h10, 0, 1'b0);

        // ClearA_LoadB ignored in CALC and HOLD, honoured in IDLE
        load_b(8'h07);
        run_div(8'h64, 2, 1'b1);
        load_b(8'h09);
        chk("idle_load_q_kept", Qval, 8'h0E);

        // Both buttons low in IDLE: load wins, no division starts
        Run          = 1'b0;
        ClearA_LoadB = 1'b0;
        S            = 8'h05;
        step();
        chk("prio_b", Bval, 8'h05);
        chk("prio_busy", Busy, 1'b0);
        step();
        chk("prio_busy2", Busy, 1'b0);
        Run          = 1'b1;
        ClearA_LoadB = 1'b1;
        b_model      = 8'h05;
        step();

        // Reset during the 4th CALC cycle
        S   = 8'h64;
        Run = 1'b0;
        step();
        chk("mid_busy_start", Busy, 1'b1);
        step();
        step();
        step();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        Run   = 1'b1;
        chk("mid_rst_a", Aval, 8'h00);
        chk("mid_rst_b", Bval, 8'h00);
        chk("mid_rst_q", Qval, 8'h00);
        chk("mid_rst_busy", Busy, 1'b0);
        chk("mid_rst_done", Done, 1'b0);
        chk("mid_rst_x", X, 1'b0);
        step();
        chk("post_rst_idle", Busy, 1'b0);
        b_model = 8'h00;
        load_b(8'h07);
        run_div(8'h64, 0, 1'b0);

        chk("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
